// File: rtl/transconv.sv
// -----------------------------------------------------------------------------
// transconv
// Streaming 3x3 stride-2 transposed convolution (2x upsampling) for the U-Net
// decoder path. One signed 8-bit input row is loaded with read cycles; the
// write cycles then produce the two output rows (2x wide) that this input row
// completes. The previous input row is kept in the other half of a ping-pong
// line buffer so that kernel-row-3 contributions land in the next block.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous reset, active-low
//   in             signed 8-bit input pixel, taken in read cycles
//   w1..w9         signed 8-bit kernel, row-major (w1..w3 top row)
//   bias           signed 8-bit offset added to every output pixel
//   width          output row length W (even); input row length is W/2
//   flip           ping-pong select: 0 -> buffer A is newest, 1 -> buffer B
//   rw             1 = read (store input pixel), 0 = write (produce pixel)
//   hop            step enable; 0 holds all state
//   pixel          registered signed 20-bit output pixel
// -----------------------------------------------------------------------------
module transconv #(
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [7:0]  in,
    input  logic signed [7:0]  w1,
    input  logic signed [7:0]  w2,
    input  logic signed [7:0]  w3,
    input  logic signed [7:0]  w4,
    input  logic signed [7:0]  w5,
    input  logic signed [7:0]  w6,
    input  logic signed [7:0]  w7,
    input  logic signed [7:0]  w8,
    input  logic signed [7:0]  w9,
    input  logic signed [7:0]  bias,
    input  logic        [7:0]  width,
    input  logic               flip,
    input  logic               rw,
    input  logic               hop,
    output logic signed [19:0] pixel
);

    // A degenerate zero-height map still gets a one-entry buffer so that all
    // indexing below stays legal.
    localparam int DEPTH = (IMAGE_HEIGHT > 0 && IMAGE_WIDTH >= 2) ? IMAGE_WIDTH / 2 : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_8 = 8'(DEPTH);

    logic signed [7:0]  buf_a_r [DEPTH];
    logic signed [7:0]  buf_b_r [DEPTH];
    logic        [7:0]  rc_r;
    logic        [8:0]  wc_r;
    logic signed [19:0] pixel_r;

    logic        [7:0]  half_w_s;
    logic        [8:0]  two_w_s;
    logic               row_s;
    logic        [8:0]  col_s;
    logic        [7:0]  j_s;
    logic signed [7:0]  cur_j_s;
    logic signed [7:0]  cur_jm1_s;
    logic signed [7:0]  prev_j_s;
    logic signed [7:0]  prev_jm1_s;
    logic signed [19:0] sum_s;

    // Full-precision signed 8x8 product, sign-extended to the accumulator width.
    function automatic logic signed [19:0] mul_ext(input logic signed [7:0] a,
                                                   input logic signed [7:0] b);
        logic signed [15:0] p;
        p = a * b;
        return 20'(p);
    endfunction

    // Buffer read with out-of-range columns (width larger than the buffer)
    // reading as zero instead of aliasing.
    function automatic logic signed [7:0] pick(input logic              sel_b,
                                               input logic [7:0]        idx,
                                               input logic signed [7:0] a [DEPTH],
                                               input logic signed [7:0] b [DEPTH]);
        logic signed [7:0] v;
        if (idx < DEPTH_8) begin
            v = sel_b ? b[idx[AW-1:0]] : a[idx[AW-1:0]];
        end else begin
            v = 8'sd0;
        end
        return v;
    endfunction

    // Decode the write counter into block row, output column and input column.
    always_comb begin
        half_w_s = {1'b0, width[7:1]};
        two_w_s  = {width, 1'b0};
        row_s    = (wc_r >= {1'b0, width});
        if (row_s) begin
            col_s = wc_r - {1'b0, width};
        end else begin
            col_s = wc_r;
        end
        j_s = col_s[8:1];
    end

    // Fetch the newest-row and previous-row taps; column j-1 is zero at the left edge.
    always_comb begin
        cur_j_s  = pick(flip, j_s, buf_a_r, buf_b_r);
        prev_j_s = pick(~flip, j_s, buf_a_r, buf_b_r);
        if (j_s == 8'd0) begin
            cur_jm1_s  = 8'sd0;
            prev_jm1_s = 8'sd0;
        end else begin
            cur_jm1_s  = pick(flip, j_s - 8'd1, buf_a_r, buf_b_r);
            prev_jm1_s = pick(~flip, j_s - 8'd1, buf_a_r, buf_b_r);
        end
    end

    // Output pixel sum: the kernel phase is chosen by block row and column parity.
    always_comb begin
        sum_s = 20'(bias);
        case ({row_s, col_s[0]})
            2'b00: sum_s = 20'(bias) + mul_ext(w1, cur_j_s) + mul_ext(w3, cur_jm1_s)
                         + mul_ext(w7, prev_j_s) + mul_ext(w9, prev_jm1_s);
            2'b01: sum_s = 20'(bias) + mul_ext(w2, cur_j_s) + mul_ext(w8, prev_j_s);
            2'b10: sum_s = 20'(bias) + mul_ext(w4, cur_j_s) + mul_ext(w6, cur_jm1_s);
            2'b11: sum_s = 20'(bias) + mul_ext(w5, cur_j_s);
            default: sum_s = 20'sd0;
        endcase
    end

    // Line buffers, read/write counters and the output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_a_r[i] <= 8'sd0;
                buf_b_r[i] <= 8'sd0;
            end
            rc_r    <= 8'd0;
            wc_r    <= 9'd0;
            pixel_r <= 20'sd0;
        end else if (hop) begin
            if (rw) begin
                if (rc_r < DEPTH_8) begin
                    if (flip) begin
                        buf_b_r[rc_r[AW-1:0]] <= in;
                    end else begin
                        buf_a_r[rc_r[AW-1:0]] <= in;
                    end
                end
                if ((rc_r + 8'd1) >= half_w_s) begin
                    rc_r <= 8'd0;
                end else begin
                    rc_r <= rc_r + 8'd1;
                end
                wc_r <= 9'd0;
            end else begin
                pixel_r <= sum_s;
                if ((wc_r + 9'd1) >= two_w_s) begin
                    wc_r <= 9'd0;
                end else begin
                    wc_r <= wc_r + 9'd1;
                end
                rc_r <= 8'd0;
            end
        end else begin
            pixel_r <= pixel_r;
        end
    end

    assign pixel = pixel_r;

endmodule

// File: tb/tb_transconv.sv
module tb_transconv;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [7:0]  in_px;
    logic signed [7:0]  w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic signed [7:0]  bias;
    logic        [7:0]  width;
    logic               flip;
    logic               rw;
    logic               hop;
    logic signed [19:0] pixel;

    always #5 clk = ~clk;

    transconv #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(8)) dut (
        .clk(clk), .rst(rst), .in(in_px),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
        .bias(bias), .width(width), .flip(flip), .rw(rw), .hop(hop), .pixel(pixel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int wk [9];
    int bias_v;
    int wid;
    int cur_row  [4];
    int prev_row [4];
    int exp_blk  [2][8];
    logic signed [19:0] got [16];
    logic signed [19:0] last_px;

    // Reference outputs of the directed test plan (bias 0) for rows 0, 1 and 3.
    int tab [3][16] = '{
        '{546, 154, -3, 11, -3, 0, 3900, 1100, 1134, 0, 81, 0, 0, 0, 8100, 0},
        '{14, 14, -38, -10, 3, 0, -3800, -1000, 0, 0, -81, 0, 0, 0, -8100, 0},
        '{39, 11, 75, 22, -6, 0, 39, 11, 81, 0, 162, 0, 0, 0, 81, 0}
    };
    int rows_tp [4][4] = '{'{14, 1, 0, 100}, '{0, -1, 0, -100}, '{0, 0, 0, 0}, '{1, 2, 0, 1}};

    task automatic check(input string tag, input logic signed [19:0] exp_v);
        n_cmp++;
        assert (pixel === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, pixel, exp_v);
        end
    endtask

    task automatic apply_cfg();
        w1 = 8'(wk[0]); w2 = 8'(wk[1]); w3 = 8'(wk[2]);
        w4 = 8'(wk[3]); w5 = 8'(wk[4]); w6 = 8'(wk[5]);
        w7 = 8'(wk[6]); w8 = 8'(wk[7]); w9 = 8'(wk[8]);
        bias  = 8'(bias_v);
        width = 8'(wid);
    endtask

    task automatic do_reset();
        rst = 1'b0; hop = 1'b1; rw = 1'b0;
        @(posedge clk); #1;
        check("reset", 20'sd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) prev_row[i] = 0;
        last_px = 20'sd0;
    endtask

    // Scatter model: each input pixel x at column jj spreads w[kr][kc]*x to
    // output column 2*jj+kc; kernel rows 0/1 fall in this block, kernel row 2
    // of the previous input row falls on row 0 of this block. Column W drops.
    task automatic model_block();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) exp_blk[r][c] = 0;
        for (int jj = 0; jj < wid / 2; jj++) begin
            for (int kc = 0; kc < 3; kc++) begin
                if (2 * jj + kc < wid) begin
                    exp_blk[0][2 * jj + kc] += wk[kc] * cur_row[jj] + wk[6 + kc] * prev_row[jj];
                    exp_blk[1][2 * jj + kc] += wk[3 + kc] * cur_row[jj];
                end
            end
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < wid; c++) exp_blk[r][c] += bias_v;
    endtask

    // One input row: W/2 reads, 2W writes, flip toggle. Optional hop hold after
    // write hold_at, or reset replacing write rst_at (row then abandoned).
    task automatic run_row(input int hold_at, input int rst_at);
        model_block();
        for (int jj = 0; jj < wid / 2; jj++) begin
            rw = 1'b1; hop = 1'b1; in_px = 8'(cur_row[jj]);
            @(posedge clk); #1;
            check("read_hold", last_px);
        end
        for (int k = 0; k < 2 * wid; k++) begin
            rw = 1'b0; hop = 1'b1;
            if (k == rst_at) begin
                rst = 1'b0;
                @(posedge clk); #1;
                check("mid_reset", 20'sd0);
                rst = 1'b1;
                for (int i = 0; i < 4; i++) prev_row[i] = 0;
                last_px = 20'sd0;
                return;
            end
            @(posedge clk); #1;
            last_px = 20'(exp_blk[k / wid][k % wid]);
            check($sformatf("write k=%0d", k), last_px);
            got[k] = pixel;
            if (k == hold_at) begin
                hop = 1'b0; rw = 1'b1; in_px = 8'sd77;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("hop_freeze", last_px);
                end
                hop = 1'b1; rw = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) prev_row[i] = cur_row[i];
        flip = ~flip;
    endtask

    task automatic check_table(input int t);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            assert (got[k] === 20'(tab[t][k] + bias_v)) else begin
                n_bad++;
                $error("FAIL table%0d k=%0d: observed %0d expected %0d", t, k, got[k], tab[t][k] + bias_v);
            end
        end
    endtask

    initial begin
        rst = 1'b0; hop = 1'b0; rw = 1'b0; flip = 1'b0; in_px = 8'sd0;
        wk = '{39, 11, -3, 81, 0, 0, 1, 1, 0};
        bias_v = 0; wid = 8;
        for (int i = 0; i < 4; i++) cur_row[i] = 0;
        apply_cfg();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed test plan rows.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) cur_row[i] = rows_tp[r][i];
            run_row(-1, -1);
            if (r == 0) check_table(0);
            if (r == 1) check_table(1);
            if (r == 3) check_table(2);
        end

        // Row 0 again with a negative bias.
        do_reset();
        flip = 1'b0; bias_v = -5; apply_cfg();
        for (int i = 0; i < 4; i++) cur_row[i] = rows_tp[0][i];
        run_row(-1, -1);
        check_table(0);

        // Reset in the middle of a write phase, then re-feed row 0.
        bias_v = 0; apply_cfg();
        for (int i = 0; i < 4; i++) cur_row[i] = rows_tp[1][i];
        run_row(-1, 5);
        for (int i = 0; i < 4; i++) cur_row[i] = rows_tp[0][i];
        run_row(-1, -1);
        check_table(0);

        // Step-enable hold mid write phase.
        for (int i = 0; i < 4; i++) cur_row[i] = rows_tp[3][i];
        run_row(6, -1);

        // Randomized images against the scatter model.
        for (int img = 0; img < 4; img++) begin
            wid = 2 * int'($urandom_range(1, 4));
            for (int i = 0; i < 9; i++) wk[i] = int'($urandom_range(0, 255)) - 128;
            bias_v = int'($urandom_range(0, 255)) - 128;
            apply_cfg();
            do_reset();
            for (int r = 0; r < 5; r++) begin
                for (int i = 0; i < 4; i++) cur_row[i] = (i < wid / 2) ? int'($urandom_range(0, 255)) - 128 : 0;
                run_row((r == 2) ? int'($urandom_range(0, 2 * wid - 1)) : -1, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
